// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake bundle between the PC sequencer and its environment.
// The sequencer is the fetch master; instruction memory and execute stage form the slave side.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        ex_done;
    logic        stall;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  ex_done,
        input  stall
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output ex_done,
        output stall
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the BOOT/FETCH/EXEC handshake, computes next PC.
// Optional feature macro MISALIGN_TRAP_EN: misaligned taken targets trap to TRAP_VEC instead of being aligned.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        bus,
    input  logic                  i_take_branch,
    input  logic                  i_is_jalr,
    input  logic [31:0]           i_imm,
    input  logic [31:0]           i_rs1_val,
    output logic [31:0]           o_pc,
    output logic [31:0]           o_pc_plus4,
    output logic                  o_redirect,
    output logic [31:0]           o_br_taken_cnt,
    output logic                  o_trap,
    output logic [31:0]           o_trap_addr
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_imem_req;
    logic        w_imem_req_nxt;
    logic [31:0] r_pc;
    logic        r_redirect;
    logic [31:0] r_br_taken_cnt;
    logic        w_advance;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;

    function automatic logic [31:0] f_jalr_target(input logic [31:0] base, input logic [31:0] ofs);
        f_jalr_target = (base + ofs) & ~32'h0000_0001;
    endfunction

    function automatic logic f_misaligned(input logic [31:0] tgt);
        f_misaligned = ((tgt & 32'h0000_0003) != 32'h0000_0000);
    endfunction

    assign w_seq_pc  = r_pc + 32'd4;
    assign w_advance = (r_state == ST_EXEC) && bus.ex_done && !bus.stall;

    // Taken-path target: JALR outranks a branch/JAL decision.
    always_comb begin
        w_taken = i_is_jalr | i_take_branch;
        if (i_is_jalr) begin
            w_target = f_jalr_target(i_rs1_val, i_imm);
        end else begin
            w_target = r_pc + i_imm;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        w_misalign;
    logic        r_trap;
    logic [31:0] r_trap_addr;

    assign w_misalign = w_taken && f_misaligned(w_target);

    // Next PC with misaligned targets diverted to the trap vector.
    always_comb begin
        if (w_misalign) begin
            w_next_pc = TRAP_VEC;
        end else if (w_taken) begin
            w_next_pc = w_target;
        end else begin
            w_next_pc = w_seq_pc;
        end
    end

    // Trap pulse and offending address capture, aligned with the redirect slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trap      <= 1'b0;
            r_trap_addr <= 32'h0000_0000;
        end else begin
            r_trap <= w_advance && w_misalign;
            if (w_advance && w_misalign) begin
                r_trap_addr <= w_target;
            end else begin
                r_trap_addr <= r_trap_addr;
            end
        end
    end

    assign o_trap      = r_trap;
    assign o_trap_addr = r_trap_addr;
`else
    // Next PC with taken targets silently forced to word alignment.
    always_comb begin
        if (w_taken) begin
            w_next_pc = w_target & ~32'h0000_0003;
        end else begin
            w_next_pc = w_seq_pc;
        end
    end

    assign o_trap      = 1'b0;
    assign o_trap_addr = 32'h0000_0000;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (w_advance) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    // FSM output decode, one cycle ahead so the request leaves a flop.
    always_comb begin
        w_imem_req_nxt = 1'b0;
        case (w_state_nxt)
            ST_FETCH: w_imem_req_nxt = 1'b1;
            ST_BOOT:  w_imem_req_nxt = 1'b0;
            ST_EXEC:  w_imem_req_nxt = 1'b0;
            default:  w_imem_req_nxt = 1'b0;
        endcase
    end

    // Registered fetch request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_imem_req <= 1'b0;
        end else begin
            r_imem_req <= w_imem_req_nxt;
        end
    end

    // PC, redirect pulse and taken counter all update on the EXEC->FETCH edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc           <= RESET_PC;
            r_redirect     <= 1'b0;
            r_br_taken_cnt <= 32'h0000_0000;
        end else begin
            r_redirect <= w_advance && w_taken;
            if (w_advance) begin
                r_pc <= w_next_pc;
            end else begin
                r_pc <= r_pc;
            end
            if (w_advance && w_taken) begin
                r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
            end else begin
                r_br_taken_cnt <= r_br_taken_cnt;
            end
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign o_pc           = r_pc;
    assign o_pc_plus4     = w_seq_pc;
    assign o_redirect     = r_redirect;
    assign o_br_taken_cnt = r_br_taken_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetch results, a monitor checks each new fetch.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        take_branch;
    logic        is_jalr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_redirect;
    logic [31:0] o_br_taken_cnt;
    logic        o_trap;
    logic [31:0] o_trap_addr;

    pc_sequencer_if u_if();

    pc_sequencer u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (u_if.master),
        .i_take_branch  (take_branch),
        .i_is_jalr      (is_jalr),
        .i_imm          (imm),
        .i_rs1_val      (rs1_val),
        .o_pc           (o_pc),
        .o_pc_plus4     (o_pc_plus4),
        .o_redirect     (o_redirect),
        .o_br_taken_cnt (o_br_taken_cnt),
        .o_trap         (o_trap),
        .o_trap_addr    (o_trap_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        redir;
        logic [31:0] cnt;
        logic        trap;
        logic [31:0] taddr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_cnt    = 32'd0;
    logic [31:0] m_taddr  = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic redir, input logic trap);
        exp_t e;
        e.addr  = addr;
        e.redir = redir;
        e.cnt   = m_cnt;
        e.trap  = trap;
        e.taddr = m_taddr;
        sb_q.push_back(e);
    endtask

    // Monitor: each new fetch request pops one expectation; all other cycles must show no pulses.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev = 1'b0;
            end else begin
                if (u_if.imem_req === 1'b1 && !prev) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_fetch: got addr %h expected no fetch", u_if.imem_addr);
                    end else begin
                        e = sb_q.pop_front();
                        check32("fetch_addr", u_if.imem_addr, e.addr);
                        check32("pc", o_pc, e.addr);
                        check32("redirect", {31'd0, o_redirect}, {31'd0, e.redir});
                        check32("br_taken_cnt", o_br_taken_cnt, e.cnt);
                        check32("trap", {31'd0, o_trap}, {31'd0, e.trap});
                        check32("trap_addr", o_trap_addr, e.taddr);
                    end
                end else begin
                    check32("redirect_idle", {31'd0, o_redirect}, 32'd0);
                    check32("trap_idle", {31'd0, o_trap}, 32'd0);
                end
                prev = u_if.imem_req;
            end
        end
    end

    task automatic wait_fetch();
        int t;
        t = 0;
        while (u_if.imem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL fetch_timeout: got no imem_req expected one within 50 cycles");
        end
    endtask

    // One instruction: fetch with optional backpressure, execute with optional stall.
    task automatic do_instr(input logic jalr, input logic br, input logic [31:0] imm_v,
                            input logic [31:0] rs1_v, input int rdy_dly, input int stl,
                            input logic [31:0] exp_pc, input logic exp_trap,
                            input logic [31:0] exp_taddr);
        logic [31:0] a;
        logic [31:0] pcb;
        wait_fetch();
        a = u_if.imem_addr;
        for (int i = 0; i < rdy_dly; i++) begin
            u_if.imem_ready = 1'b0;
            @(negedge clk);
            check32("bp_req_held", {31'd0, u_if.imem_req}, 32'd1);
            check32("bp_addr_stable", u_if.imem_addr, a);
        end
        u_if.imem_ready = 1'b1;
        @(negedge clk);
        u_if.imem_ready = 1'b0;
        check32("exec_req_low", {31'd0, u_if.imem_req}, 32'd0);
        is_jalr      = jalr;
        take_branch  = br;
        imm          = imm_v;
        rs1_val      = rs1_v;
        u_if.ex_done = 1'b1;
        pcb          = o_pc;
        for (int i = 0; i < stl; i++) begin
            u_if.stall = 1'b1;
            @(negedge clk);
            check32("stall_pc_held", o_pc, pcb);
            check32("stall_req_low", {31'd0, u_if.imem_req}, 32'd0);
        end
        u_if.stall = 1'b0;
        if (jalr | br) m_cnt = m_cnt + 32'd1;
        if (exp_trap) m_taddr = exp_taddr;
        push_exp(exp_pc, jalr | br, exp_trap);
        @(negedge clk);
        u_if.ex_done = 1'b0;
        is_jalr      = 1'b0;
        take_branch  = 1'b0;
        imm          = 32'd0;
        rs1_val      = 32'd0;
    endtask

    initial begin : stim
        rst             = 1'b0;
        take_branch     = 1'b0;
        is_jalr         = 1'b0;
        imm             = 32'd0;
        rs1_val         = 32'd0;
        u_if.imem_ready = 1'b0;
        u_if.ex_done    = 1'b0;
        u_if.stall      = 1'b0;
        push_exp(32'h0000_0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check32("rst_pc", o_pc, 32'h0000_0000);
        check32("rst_req", {31'd0, u_if.imem_req}, 32'd0);
        check32("rst_cnt", o_br_taken_cnt, 32'd0);
        rst = 1'b1;
        #1;
        check32("boot_req_low", {31'd0, u_if.imem_req}, 32'd0);

        do_instr(1'b1, 1'b0, 32'h0,         32'h0000_0010, 0, 0, 32'h0000_0010, 1'b0, 32'h0);
        check32("pc_plus4_0x10", o_pc_plus4, 32'h0000_0014);
        do_instr(1'b0, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0014, 1'b0, 32'h0);
        do_instr(1'b1, 1'b0, 32'h0,         32'h0000_0100, 0, 0, 32'h0000_0100, 1'b0, 32'h0);
        do_instr(1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0,         0, 0, 32'h0000_00F8, 1'b0, 32'h0);
        do_instr(1'b0, 1'b0, 32'h0,         32'h0,         5, 3, 32'h0000_00FC, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        do_instr(1'b1, 1'b1, 32'h0,         32'h0000_0203, 0, 0, 32'h0000_0100, 1'b1, 32'h0000_0202);
`else
        do_instr(1'b1, 1'b1, 32'h0,         32'h0000_0203, 0, 0, 32'h0000_0200, 1'b0, 32'h0);
`endif
        do_instr(1'b1, 1'b0, 32'h0000_0008, 32'hFFFF_FFFC, 0, 0, 32'h0000_0004, 1'b0, 32'h0);
        do_instr(1'b1, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0000, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        do_instr(1'b0, 1'b1, 32'h0000_0006, 32'h0,         0, 0, 32'h0000_0100, 1'b1, 32'h0000_0006);
        do_instr(1'b0, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0104, 1'b0, 32'h0);
`else
        do_instr(1'b0, 1'b1, 32'h0000_0006, 32'h0,         0, 0, 32'h0000_0004, 1'b0, 32'h0);
        do_instr(1'b0, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0008, 1'b0, 32'h0);
`endif
        do_instr(1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        check32("pc_plus4_wrap", o_pc_plus4, 32'h0000_0000);
        do_instr(1'b0, 1'b0, 32'h0,         32'h0,         0, 0, 32'h0000_0000, 1'b0, 32'h0);
        do_instr(1'b1, 1'b0, 32'h0,         32'h0000_0040, 0, 0, 32'h0000_0040, 1'b0, 32'h0);

        // Reset in the middle of EXEC at pc=0x40.
        wait_fetch();
        u_if.imem_ready = 1'b1;
        @(negedge clk);
        u_if.imem_ready = 1'b0;
        check32("pre_rst_pc", o_pc, 32'h0000_0040);
        #2;
        rst = 1'b0;
        #1;
        check32("midexec_rst_pc", o_pc, 32'h0000_0000);
        check32("midexec_rst_req", {31'd0, u_if.imem_req}, 32'd0);
        check32("midexec_rst_cnt", o_br_taken_cnt, 32'd0);
        m_cnt   = 32'd0;
        m_taddr = 32'd0;
        push_exp(32'h0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check32("rerelease_req_low", {31'd0, u_if.imem_req}, 32'd0);
        repeat (3) @(negedge clk);
        check32("queue_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
